// File: rtl/legv8_mc_control_if.sv
// Memory handshake bundle between the multi-cycle controller and the
// instruction/data memories. The controller drives the requests, the
// memories answer with single-cycle acks.
interface legv8_mc_control_if;
   logic imem_req;
   logic imem_ack;
   logic dmem_req;
   logic dmem_we;
   logic dmem_ack;

   modport master (
      output imem_req,
      output dmem_req,
      output dmem_we,
      input  imem_ack,
      input  dmem_ack
   );

   modport slave (
      input  imem_req,
      input  dmem_req,
      input  dmem_we,
      output imem_ack,
      output dmem_ack
   );
endinterface

// File: rtl/legv8_mc_control.sv
// Multi-cycle control FSM for the LEGv8 core.
// Sequences FETCH/DECODE/EXEC/MEM/WB, runs the memory req/ack handshakes with
// a wait-cycle limit that traps into an absorbing FAULT state, and counts
// retired instructions. Control outputs are decoded from the current state,
// the latched opcode and the ack/zero inputs of the current cycle, so an
// asynchronous reset silences them immediately.
module legv8_mc_control #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 en,
   input  logic [10:0]          opcode,
   input  logic                 alu_zero,
   legv8_mc_control_if.master   mem,
   output logic                 ir_write,
   output logic                 pc_write,
   output logic                 pc_src,
   output logic                 reg_write,
   output logic                 reg2_loc,
   output logic                 alu_src,
   output logic                 mem_to_reg,
   output logic [3:0]           alu_ctl,
   output logic [CNT_W-1:0]     retired,
   output logic                 illegal_op,
   output logic                 fault
);

   localparam int TW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
   localparam logic [TW-1:0] WAIT_LAST = TW'(MEM_TIMEOUT - 1);

   localparam logic [10:0] OP_STUR = 11'h7C0;
   localparam logic [10:0] OP_LDUR = 11'h7C2;
   localparam logic [10:0] OP_SUBI = 11'h344;
   localparam logic [10:0] OP_SUB  = 11'h658;
   localparam logic [10:0] OP_ORR  = 11'h550;
   localparam logic [10:0] OP_ADDI = 11'h244;
   localparam logic [10:0] OP_ADD  = 11'h458;
   localparam logic [10:0] OP_AND  = 11'h450;
   localparam logic [10:0] OP_CBZ  = 11'h0B4;
   localparam logic [10:0] OP_CBNZ = 11'h0B5;
   localparam logic [10:0] OP_B    = 11'h005;
   localparam logic [10:0] OP_NOP  = 11'h000;

   localparam logic [3:0] ALU_ADD   = 4'b0010;
   localparam logic [3:0] ALU_SUB   = 4'b0110;
   localparam logic [3:0] ALU_AND   = 4'b0000;
   localparam logic [3:0] ALU_ORR   = 4'b0001;
   localparam logic [3:0] ALU_PASSB = 4'b0111;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_FAULT
   } state_t;

   state_t           state_q, state_d;
   logic [10:0]      op_q, op_d;
   logic [TW-1:0]    cnt_q, cnt_d;
   logic [CNT_W-1:0] retired_q, retired_d;
   logic             end_instr;
   logic             retire;
   logic             imem_req_o;
   logic             dmem_req_o;
   logic             dmem_we_o;

   function automatic logic is_known(input logic [10:0] op);
      case (op)
         OP_STUR, OP_LDUR, OP_SUBI, OP_SUB, OP_ORR, OP_ADDI,
         OP_ADD, OP_AND, OP_CBZ, OP_CBNZ, OP_B, OP_NOP: is_known = 1'b1;
         default:                                        is_known = 1'b0;
      endcase
   endfunction

   // Next-state, wait counter, opcode latch and retire bookkeeping.
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      cnt_d     = cnt_q;
      retired_d = retired_q;
      end_instr = 1'b0;
      retire    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (en) begin
               state_d = S_FETCH;
               cnt_d   = '0;
            end
         end
         S_FETCH: begin
            if (mem.imem_ack) begin
               state_d = S_DECODE;
            end else if (cnt_q == WAIT_LAST) begin
               state_d = S_FAULT;
            end else begin
               cnt_d = cnt_q + TW'(1);
            end
         end
         S_DECODE: begin
            op_d = opcode;
            if (opcode == OP_NOP || !is_known(opcode)) begin
               end_instr = 1'b1;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            case (op_q)
               OP_LDUR, OP_STUR: begin
                  state_d = S_MEM;
                  cnt_d   = '0;
               end
               OP_CBZ, OP_CBNZ, OP_B: begin
                  end_instr = 1'b1;
                  retire    = 1'b1;
               end
               default: state_d = S_WB;
            endcase
         end
         S_MEM: begin
            if (mem.dmem_ack) begin
               if (op_q == OP_LDUR) begin
                  state_d = S_WB;
               end else begin
                  end_instr = 1'b1;
                  retire    = 1'b1;
               end
            end else if (cnt_q == WAIT_LAST) begin
               state_d = S_FAULT;
            end else begin
               cnt_d = cnt_q + TW'(1);
            end
         end
         S_WB: begin
            end_instr = 1'b1;
            retire    = 1'b1;
         end
         S_FAULT: state_d = S_FAULT;
         default: state_d = S_IDLE;
      endcase
      if (end_instr) begin
         state_d = en ? S_FETCH : S_IDLE;
         cnt_d   = '0;
      end
      if (retire) begin
         retired_d = retired_q + CNT_W'(1);
      end
   end

   // State, latched opcode, wait counter and retired count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         op_q      <= '0;
         cnt_q     <= '0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         cnt_q     <= cnt_d;
         retired_q <= retired_d;
      end
   end

   // Datapath controls for the current state; everything idles low by default.
   always_comb begin
      imem_req_o = 1'b0;
      dmem_req_o = 1'b0;
      dmem_we_o  = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      reg_write  = 1'b0;
      reg2_loc   = 1'b0;
      alu_src    = 1'b0;
      mem_to_reg = 1'b0;
      alu_ctl    = ALU_AND;
      illegal_op = 1'b0;
      fault      = 1'b0;
      case (state_q)
         S_FETCH: begin
            imem_req_o = 1'b1;
            if (mem.imem_ack) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
            end
         end
         S_DECODE: begin
            illegal_op = (opcode != OP_NOP) && !is_known(opcode);
         end
         S_EXEC: begin
            case (op_q)
               OP_ADD:  alu_ctl = ALU_ADD;
               OP_SUB:  alu_ctl = ALU_SUB;
               OP_AND:  alu_ctl = ALU_AND;
               OP_ORR:  alu_ctl = ALU_ORR;
               OP_ADDI, OP_LDUR, OP_STUR: begin
                  alu_ctl = ALU_ADD;
                  alu_src = 1'b1;
               end
               OP_SUBI: begin
                  alu_ctl = ALU_SUB;
                  alu_src = 1'b1;
               end
               OP_CBZ, OP_CBNZ: begin
                  alu_ctl  = ALU_PASSB;
                  reg2_loc = 1'b1;
                  pc_src   = 1'b1;
                  pc_write = (op_q == OP_CBZ) ? alu_zero : ~alu_zero;
               end
               OP_B: begin
                  pc_write = 1'b1;
                  pc_src   = 1'b1;
               end
               default: alu_ctl = ALU_AND;
            endcase
         end
         S_MEM: begin
            dmem_req_o = 1'b1;
            if (op_q == OP_STUR) begin
               dmem_we_o = 1'b1;
               reg2_loc  = 1'b1;
            end
         end
         S_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = (op_q == OP_LDUR);
         end
         S_FAULT: fault = 1'b1;
         default: ;
      endcase
   end

   assign mem.imem_req = imem_req_o;
   assign mem.dmem_req = dmem_req_o;
   assign mem.dmem_we  = dmem_we_o;
   assign retired      = retired_q;

endmodule
